// File: rtl/cpu_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: widths, PC stepping
// constants, the fetch FSM state type and a saturating counter helper.
package cpu_fetch_pkg;

    localparam int ADDR_W         = 22;
    localparam int INSTR_W        = 22;
    localparam int MEM_WORDS      = 129;
    localparam int RESET_PC       = 0;
    localparam int PC_STEP        = 4;
    localparam int PC_READ_OFFSET = 8;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        HALT  = 1'b1
    } fetch_state_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/program_counter.sv
// Program counter register: synchronous reset, redirect load, sequential
// increment by one instruction word, otherwise hold.
module program_counter
    import cpu_fetch_pkg::*;
#(
    parameter int ADDR_W   = cpu_fetch_pkg::ADDR_W,
    parameter int RESET_PC = cpu_fetch_pkg::RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_load_pc,
    input  logic              i_inc,
    output logic [ADDR_W-1:0] o_pc
);

    logic [ADDR_W-1:0] r_pc;

    // Load has priority over increment so a branch wins over sequential flow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= ADDR_W'(RESET_PC);
        end else if (i_load) begin
            r_pc <= i_load_pc;
        end else if (i_inc) begin
            r_pc <= r_pc + ADDR_W'(PC_STEP);
        end else begin
            r_pc <= r_pc;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the ROM address from the PC, registers the
// fetched word toward decode, handles redirects and halts on bad addresses.
module fetch_unit
    import cpu_fetch_pkg::*;
#(
    parameter int ADDR_W    = cpu_fetch_pkg::ADDR_W,
    parameter int INSTR_W   = cpu_fetch_pkg::INSTR_W,
    parameter int MEM_WORDS = cpu_fetch_pkg::MEM_WORDS,
    parameter int RESET_PC  = cpu_fetch_pkg::RESET_PC
) (
    input  logic               clk,
    input  logic               rst,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rd,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [ADDR_W-1:0]  out_pc_plus8,
    output logic               fault,
    output logic [ADDR_W-1:0]  fault_pc,
    output logic [31:0]        fetch_count
);

    localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(MEM_WORDS);

    fetch_state_t       r_state;
    fetch_state_t       w_state_nxt;
    logic [ADDR_W-1:0]  w_pc;
    logic [ADDR_W-1:0]  w_imem_addr;
    logic               w_fetching;
    logic               w_bad;
    logic               w_can_capture;
    logic               w_capture;
    logic               w_fault_evt;
    logic               w_pc_load;

    logic               r_out_valid;
    logic [INSTR_W-1:0] r_out_instr;
    logic [ADDR_W-1:0]  r_out_pc;
    logic [ADDR_W-1:0]  r_out_pc_plus8;
    logic               r_fault;
    logic [ADDR_W-1:0]  r_fault_pc;
    logic [31:0]        r_fetch_count;

    // Word index is compared zero-extended so the limit check never truncates.
    assign w_bad = (w_pc[1:0] != 2'b00) ||
                   ({2'b00, w_pc[ADDR_W-1:2]} >= MEM_LIMIT);

    assign w_can_capture = w_fetching && !redirect_valid &&
                           (!r_out_valid || out_ready);
    assign w_capture     = w_can_capture && !w_bad;
    assign w_fault_evt   = w_can_capture && w_bad;
    assign w_pc_load     = w_fetching && redirect_valid;

    program_counter #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_pc_load),
        .i_load_pc (redirect_pc),
        .i_inc     (w_capture),
        .o_pc      (w_pc)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: HALT is only left through reset.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            FETCH: begin
                if (w_fault_evt) begin
                    w_state_nxt = HALT;
                end else begin
                    w_state_nxt = FETCH;
                end
            end
            HALT:    w_state_nxt = HALT;
            default: w_state_nxt = HALT;
        endcase
    end

    // FSM outputs: fetch enable and the address presented to the ROM.
    always_comb begin
        w_fetching  = 1'b0;
        w_imem_addr = r_fault_pc;
        case (r_state)
            FETCH: begin
                w_fetching  = 1'b1;
                w_imem_addr = w_pc;
            end
            HALT: begin
                w_fetching  = 1'b0;
                w_imem_addr = r_fault_pc;
            end
            default: begin
                w_fetching  = 1'b0;
                w_imem_addr = r_fault_pc;
            end
        endcase
    end

    // Output register toward decode plus the sticky fault record.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid    <= 1'b0;
            r_out_instr    <= '0;
            r_out_pc       <= '0;
            r_out_pc_plus8 <= ADDR_W'(PC_READ_OFFSET);
            r_fault        <= 1'b0;
            r_fault_pc     <= '0;
        end else if (w_pc_load) begin
            r_out_valid    <= 1'b0;
        end else if (w_fault_evt) begin
            r_out_valid    <= 1'b0;
            r_fault        <= 1'b1;
            r_fault_pc     <= w_pc;
        end else if (w_capture) begin
            r_out_valid    <= 1'b1;
            r_out_instr    <= imem_rd;
            r_out_pc       <= w_pc;
            r_out_pc_plus8 <= w_pc + ADDR_W'(PC_READ_OFFSET);
        end else if (r_out_valid && out_ready) begin
            r_out_valid    <= 1'b0;
        end else begin
            r_out_valid    <= r_out_valid;
        end
    end

    // Captured-instruction counter, saturating rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_count <= 32'd0;
        end else if (w_capture) begin
            r_fetch_count <= sat_inc32(r_fetch_count);
        end else begin
            r_fetch_count <= r_fetch_count;
        end
    end

    assign imem_addr    = w_imem_addr;
    assign out_valid    = r_out_valid;
    assign out_instr    = r_out_instr;
    assign out_pc       = r_out_pc;
    assign out_pc_plus8 = r_out_pc_plus8;
    assign fault        = r_fault;
    assign fault_pc     = r_fault_pc;
    assign fetch_count  = r_fetch_count;

endmodule
